// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment display blocks: blank pattern,
// active-low hex segment table and the scan FSM state type.
package seven_seg_pkg;

  // All segments off (active-low drive).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns, entry n is hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  typedef enum logic {
    GAP  = 1'b0,
    SHOW = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seven_segment_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup; every nibble value has an entry.
  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Time-multiplexed N-digit common-anode seven-segment driver.
// Scans digits with a fixed dwell and an all-off gap between digits.
// Display data is double-buffered: a load lands in a pending buffer and is
// committed only when digit 0 of a new frame is entered, so a frame never
// shows a mix of old and new data. Outputs are registered from the next
// state so seg/an/frame_start change exactly on the edge that enters a state.
module seven_segment_scan_controller
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                    clk_1kHz,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lzb,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int MAXC = (DWELL > GAP_CYCLES) ? DWELL : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] GAP_LEN  = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] SHOW_LEN = CW'(DWELL);

  // Scan state. The counter holds the 1-based cycle number within the
  // current state; reset leaves it at 0, so the very first gap after reset
  // is one cycle longer and digit 0 first appears on edge GAP_CYCLES+1.
  scan_state_t             state, state_n;
  logic [IW-1:0]           idx, idx_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic                    enter_show;
  logic                    commit;

  // Pending and committed display buffers.
  logic [4*NUM_DIGITS-1:0] pend_d, com_d, com_d_n;
  logic [NUM_DIGITS-1:0]   pend_e, com_e, com_e_n;
  logic                    pend_l, com_l, com_l_n;
  logic                    pend_v;

  // Digit selection and blanking.
  logic [3:0]              nibble;
  logic [6:0]              dec_seg;
  logic                    upper_zero;
  logic                    blank;

  // Next-state logic: count the dwell/gap, advance idx when SHOW ends.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    cnt_n      = cnt + CW'(1);
    enter_show = 1'b0;
    case (state)
      GAP: begin
        if (cnt == GAP_LEN) begin
          state_n    = SHOW;
          cnt_n      = CW'(1);
          enter_show = 1'b1;
        end
      end
      SHOW: begin
        if (cnt == SHOW_LEN) begin
          idx_n = (idx == LAST_IDX) ? '0 : idx + IW'(1);
          cnt_n = CW'(1);
          if (GAP_CYCLES == 0) begin
            state_n    = SHOW;
            enter_show = 1'b1;
          end else begin
            state_n = GAP;
          end
        end
      end
    endcase
  end

  // Commit selection: a load on the commit edge bypasses the pending buffer.
  always_comb begin
    commit  = enter_show && (idx_n == '0);
    com_d_n = com_d;
    com_e_n = com_e;
    com_l_n = com_l;
    if (commit) begin
      if (load) begin
        com_d_n = digits;
        com_e_n = digit_en;
        com_l_n = lzb;
      end else if (pend_v) begin
        com_d_n = pend_d;
        com_e_n = pend_e;
        com_l_n = pend_l;
      end
    end
  end

  // Mux the next digit's nibble and decide whether it is blanked.
  always_comb begin
    nibble     = com_d_n[4*idx_n +: 4];
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(idx_n)) && (com_d_n[4*i +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
    blank = !com_e_n[idx_n] || (com_l_n && (idx_n != '0) && upper_zero);
  end

  seven_segment_decoder u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  // FSM state register.
  always_ff @(posedge clk_1kHz or posedge rst) begin
    if (rst) begin
      state <= GAP;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
    end
  end

  // Pending/committed buffers; the newest load always wins.
  always_ff @(posedge clk_1kHz or posedge rst) begin
    if (rst) begin
      pend_d <= '0;
      pend_e <= '0;
      pend_l <= 1'b0;
      pend_v <= 1'b0;
      com_d  <= '0;
      com_e  <= '0;
      com_l  <= 1'b0;
    end else begin
      com_d <= com_d_n;
      com_e <= com_e_n;
      com_l <= com_l_n;
      if (commit) begin
        pend_v <= 1'b0;
      end else if (load) begin
        pend_d <= digits;
        pend_e <= digit_en;
        pend_l <= lzb;
        pend_v <= 1'b1;
      end
    end
  end

  // Registered pin drive derived from a single next idx: one anode at most.
  always_ff @(posedge clk_1kHz or posedge rst) begin
    if (rst) begin
      seg         <= SEG_OFF;
      an          <= '1;
      frame_start <= 1'b0;
    end else begin
      seg         <= (state_n == SHOW && !blank) ? dec_seg : SEG_OFF;
      an          <= (state_n == SHOW) ? ~(NUM_DIGITS'(1) << idx_n) : '1;
      frame_start <= commit;
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Directed bench: default 4-digit instance (dwell 4, gap 1) plus an
// 8-digit, dwell 1, no-gap instance.
module tb_seven_segment_scan_controller;

  logic        clk_1kHz = 1'b0;
  logic        rst      = 1'b1;

  logic [15:0] a_digits = '0;
  logic [3:0]  a_en     = '0;
  logic        a_lzb    = 1'b0;
  logic        a_load   = 1'b0;
  logic [6:0]  a_seg;
  logic [3:0]  a_an;
  logic        a_fs;

  logic [31:0] b_digits = 32'h76543210;
  logic [7:0]  b_en     = 8'hFF;
  logic        b_lzb    = 1'b0;
  logic        b_load   = 1'b1;
  logic [6:0]  b_seg;
  logic [7:0]  b_an;
  logic        b_fs;

  int checks = 0;
  int errors = 0;

  logic [6:0] obs_seg [20];
  logic [3:0] obs_an  [20];
  logic       obs_fs  [20];

  logic [6:0] b_exp [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

  seven_segment_scan_controller u_a (
    .clk_1kHz    (clk_1kHz),
    .rst         (rst),
    .digits      (a_digits),
    .digit_en    (a_en),
    .lzb         (a_lzb),
    .load        (a_load),
    .seg         (a_seg),
    .an          (a_an),
    .frame_start (a_fs)
  );

  seven_segment_scan_controller #(
    .NUM_DIGITS (8),
    .DWELL      (1),
    .GAP_CYCLES (0)
  ) u_b (
    .clk_1kHz    (clk_1kHz),
    .rst         (rst),
    .digits      (b_digits),
    .digit_en    (b_en),
    .lzb         (b_lzb),
    .load        (b_load),
    .seg         (b_seg),
    .an          (b_an),
    .frame_start (b_fs)
  );

  // Clock and watchdog.
  always #5 clk_1kHz = ~clk_1kHz;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected pattern at cycle k of a 20-cycle frame (5 cycles per digit).
  function automatic logic [3:0] f_exp_an(input int k);
    return ((k % 5) < 4) ? ~(4'b0001 << (k / 5)) : 4'hF;
  endfunction

  function automatic logic [6:0] f_exp_seg(input int k, input logic [3:0][6:0] e);
    return ((k % 5) < 4) ? e[k / 5] : 7'h7F;
  endfunction

  function automatic logic f_exp_fs(input int k);
    return (k == 0);
  endfunction

  // Driver: {lzb, digit_en, digits}.
  task automatic drive_load(input logic [20:0] ld);
    a_digits = ld[15:0];
    a_en     = ld[19:16];
    a_lzb    = ld[20];
    a_load   = 1'b1;
  endtask

  // Capture one frame starting at the negedge where frame_start is high,
  // optionally driving a load for the edge following cycle k1 and/or k2.
  task automatic run_frame(input int k1, input logic [20:0] ld1,
                           input int k2, input logic [20:0] ld2);
    for (int k = 0; k < 20; k++) begin
      obs_seg[k] = a_seg;
      obs_an[k]  = a_an;
      obs_fs[k]  = a_fs;
      if (k == k1)      drive_load(ld1);
      else if (k == k2) drive_load(ld2);
      else              a_load = 1'b0;
      @(negedge clk_1kHz);
    end
    a_load = 1'b0;
  endtask

  task automatic wait_frame_start;
    int n;
    n = 0;
    while (a_fs !== 1'b1 && n < 40) begin
      @(negedge clk_1kHz);
      n++;
    end
    checks++;
    if (a_fs !== 1'b1) begin
      errors++;
      $display("FAIL wait_frame_start: frame_start=%b after %0d cycles, required 1", a_fs, n);
    end
  endtask

  task automatic test_reset;
    @(negedge clk_1kHz);
    @(negedge clk_1kHz);
    checks++;
    if (a_seg !== 7'h7F || a_an !== 4'hF || a_fs !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: seg=%h an=%b fs=%b, required seg=7f an=1111 fs=0", a_seg, a_an, a_fs);
    end
    rst = 1'b0;
    drive_load({1'b0, 4'hF, 16'h1234});
    @(negedge clk_1kHz);
    a_load = 1'b0;
    checks++;
    if (a_seg !== 7'h7F || a_an !== 4'hF || a_fs !== 1'b0) begin
      errors++;
      $display("FAIL first_gap: seg=%h an=%b fs=%b, required seg=7f an=1111 fs=0", a_seg, a_an, a_fs);
    end
    checks++;
    if (b_fs !== 1'b1 || b_an !== 8'hFE || b_seg !== 7'h40) begin
      errors++;
      $display("FAIL nogap_first_show: fs=%b an=%b seg=%h, required fs=1 an=11111110 seg=40", b_fs, b_an, b_seg);
    end
    @(negedge clk_1kHz);
    checks++;
    if (a_fs !== 1'b1 || a_an !== 4'hE || a_seg !== 7'h19) begin
      errors++;
      $display("FAIL first_show: fs=%b an=%b seg=%h, required fs=1 an=1110 seg=19", a_fs, a_an, a_seg);
    end
  endtask

  task automatic test_basic;
    logic [3:0][6:0] e;
    e = {7'h79, 7'h24, 7'h30, 7'h19};
    run_frame(10, {1'b1, 4'hF, 16'h0050}, -1, '0);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (obs_seg[k] !== f_exp_seg(k, e) || obs_an[k] !== f_exp_an(k) || obs_fs[k] !== f_exp_fs(k)) begin
        errors++;
        $display("FAIL basic k=%0d: seg=%h an=%b fs=%b, required seg=%h an=%b fs=%b",
                 k, obs_seg[k], obs_an[k], obs_fs[k], f_exp_seg(k, e), f_exp_an(k), f_exp_fs(k));
      end
    end
  endtask

  task automatic test_lzb;
    logic [3:0][6:0] e;
    e = {7'h7F, 7'h7F, 7'h12, 7'h40};
    run_frame(7, {1'b1, 4'hF, 16'h0000}, -1, '0);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (obs_seg[k] !== f_exp_seg(k, e) || obs_an[k] !== f_exp_an(k) || obs_fs[k] !== f_exp_fs(k)) begin
        errors++;
        $display("FAIL lzb_0050 k=%0d: seg=%h an=%b fs=%b, required seg=%h an=%b fs=%b",
                 k, obs_seg[k], obs_an[k], obs_fs[k], f_exp_seg(k, e), f_exp_an(k), f_exp_fs(k));
      end
    end
  endtask

  task automatic test_lzb_zero;
    logic [3:0][6:0] e;
    e = {7'h7F, 7'h7F, 7'h7F, 7'h40};
    run_frame(5, {1'b0, 4'hF, 16'hAAAA}, 15, {1'b0, 4'hF, 16'hBBBB});
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (obs_seg[k] !== f_exp_seg(k, e) || obs_an[k] !== f_exp_an(k) || obs_fs[k] !== f_exp_fs(k)) begin
        errors++;
        $display("FAIL lzb_0000 k=%0d: seg=%h an=%b fs=%b, required seg=%h an=%b fs=%b",
                 k, obs_seg[k], obs_an[k], obs_fs[k], f_exp_seg(k, e), f_exp_an(k), f_exp_fs(k));
      end
    end
  endtask

  task automatic test_overwrite;
    logic [3:0][6:0] e;
    e = {7'h03, 7'h03, 7'h03, 7'h03};
    run_frame(19, {1'b0, 4'hF, 16'hCCCC}, -1, '0);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (obs_seg[k] !== f_exp_seg(k, e) || obs_an[k] !== f_exp_an(k) || obs_fs[k] !== f_exp_fs(k)) begin
        errors++;
        $display("FAIL overwrite k=%0d: seg=%h an=%b fs=%b, required seg=%h an=%b fs=%b",
                 k, obs_seg[k], obs_an[k], obs_fs[k], f_exp_seg(k, e), f_exp_an(k), f_exp_fs(k));
      end
    end
  endtask

  task automatic test_bypass;
    logic [3:0][6:0] e;
    e = {7'h46, 7'h46, 7'h46, 7'h46};
    run_frame(-1, '0, -1, '0);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (obs_seg[k] !== f_exp_seg(k, e) || obs_an[k] !== f_exp_an(k) || obs_fs[k] !== f_exp_fs(k)) begin
        errors++;
        $display("FAIL bypass k=%0d: seg=%h an=%b fs=%b, required seg=%h an=%b fs=%b",
                 k, obs_seg[k], obs_an[k], obs_fs[k], f_exp_seg(k, e), f_exp_an(k), f_exp_fs(k));
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0][6:0] e;
    e = {7'h7F, 7'h7F, 7'h7F, 7'h7F};
    for (int k = 0; k < 10; k++) begin
      if (k == 5) drive_load({1'b0, 4'hF, 16'hDDDD});
      else        a_load = 1'b0;
      @(negedge clk_1kHz);
    end
    a_load = 1'b0;
    checks++;
    if (a_an !== 4'b1011 || a_seg !== 7'h46) begin
      errors++;
      $display("FAIL pre_reset_digit2: an=%b seg=%h, required an=1011 seg=46", a_an, a_seg);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (a_seg !== 7'h7F || a_an !== 4'hF || a_fs !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: seg=%h an=%b fs=%b, required seg=7f an=1111 fs=0", a_seg, a_an, a_fs);
    end
    @(negedge clk_1kHz);
    rst = 1'b0;
    wait_frame_start();
    run_frame(-1, '0, -1, '0);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (obs_seg[k] !== f_exp_seg(k, e) || obs_an[k] !== f_exp_an(k) || obs_fs[k] !== f_exp_fs(k)) begin
        errors++;
        $display("FAIL after_reset k=%0d: seg=%h an=%b fs=%b, required seg=%h an=%b fs=%b",
                 k, obs_seg[k], obs_an[k], obs_fs[k], f_exp_seg(k, e), f_exp_an(k), f_exp_fs(k));
      end
    end
  endtask

  task automatic test_nogap;
    int n;
    n = 0;
    while (b_fs !== 1'b1 && n < 20) begin
      @(negedge clk_1kHz);
      n++;
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (b_an !== ~(8'b1 << (k % 8)) || b_seg !== b_exp[k % 8] || b_fs !== ((k % 8) == 0)) begin
        errors++;
        $display("FAIL nogap k=%0d: an=%b seg=%h fs=%b, required an=%b seg=%h fs=%b",
                 k, b_an, b_seg, b_fs, ~(8'b1 << (k % 8)), b_exp[k % 8], ((k % 8) == 0));
      end
      @(negedge clk_1kHz);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lzb();
    test_lzb_zero();
    test_overwrite();
    test_bypass();
    test_reset_mid();
    test_nogap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
